// File: rtl/stump_sequencer_pkg.sv
// Shared state codes and opcode constants for the Stump control sequencer.
// The state codes match what Stump_control_decode expects on its state input.
package stump_sequencer_pkg;

    localparam logic [1:0] FETCH_C   = 2'b00;
    localparam logic [1:0] EXECUTE_C = 2'b01;
    localparam logic [1:0] MEMORY_C  = 2'b10;

    localparam logic [2:0] OP_LDST = 3'b110;

    typedef enum logic [1:0] {
        ST_FETCH   = FETCH_C,
        ST_EXECUTE = EXECUTE_C,
        ST_MEMORY  = MEMORY_C
    } seq_state_e;

    function automatic logic is_ldst(input logic [15:0] ir);
        return ir[15:13] == OP_LDST;
    endfunction

endpackage

// File: rtl/stump_sequencer_wait_watchdog.sv
// Memory wait-state counter for the Stump sequencer: counts stalled cycles,
// saturates at WAIT_MAX, and flags expiry when a stall would exceed it.
module stump_wait_watchdog #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic count_en_i,
    input  logic clear_i,
    output logic wait_zero_o,
    output logic expire_o
);

    localparam int unsigned W = $clog2(WAIT_MAX + 1);
    localparam logic [W-1:0] MAX_C = W'(WAIT_MAX);

    logic [W-1:0] cnt_q, cnt_d;

    assign wait_zero_o = (cnt_q == '0);
    assign expire_o    = count_en_i && (cnt_q == MAX_C);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (count_en_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stump_sequencer.sv
// Stump FETCH/EXECUTE/MEMORY sequencer with run/stop control and wait watchdog.
// Optional performance counters are built only when STUMP_SEQ_PERF_EN is defined.
//
// state   | meaning
// FETCH   | instruction fetch; run sampled here when no wait is pending
// EXECUTE | single decode/execute cycle; LD/ST continues to MEMORY
// MEMORY  | data access for LD/ST, held until mem_ready
module stump_sequencer
    import stump_sequencer_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
`ifdef STUMP_SEQ_PERF_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        run_i,
    input  logic [15:0] ir_i,
    input  logic        mem_ready_i,
    output logic [1:0]  state_o,
    output logic        mem_req_o,
    output logic        ir_en_o,
    output logic        step_done_o,
    output logic        halted_o,
    output logic        timeout_err_o
`ifdef STUMP_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
`endif
);

    seq_state_e state_q, state_d;
    logic       halted_q, halted_d;
    logic       timeout_q, timeout_d;
    logic       halt_now;
    logic       at_boundary;
    logic       wait_zero;
    logic       expire;
    logic       count_en;
    logic       unused_ir;

    assign unused_ir = ^ir_i[12:0];

    stump_wait_watchdog #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_watchdog (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .count_en_i  (count_en),
        .clear_i     (state_d != state_q),
        .wait_zero_o (wait_zero),
        .expire_o    (expire)
    );

    // run only takes effect between instructions, i.e. in FETCH before any stall
    assign at_boundary = (state_q == ST_FETCH) && wait_zero;
    assign halt_now    = at_boundary ? (~run_i | timeout_q) : halted_q;
    assign count_en    = mem_req_o & ~mem_ready_i;

    always_comb begin
        state_d     = state_q;
        halted_d    = halt_now;
        timeout_d   = timeout_q;
        mem_req_o   = 1'b0;
        ir_en_o     = 1'b0;
        step_done_o = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req_o = ~halt_now;
                if (!halt_now && mem_ready_i) begin
                    ir_en_o = 1'b1;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (is_ldst(ir_i)) begin
                    state_d = ST_MEMORY;
                end else begin
                    step_done_o = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_MEMORY: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    step_done_o = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Expiry only happens with mem_ready low, so no ir_en/step_done to undo
        if (expire) begin
            state_d   = ST_FETCH;
            halted_d  = 1'b1;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_FETCH;
            halted_q  <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            timeout_q <= timeout_d;
        end
    end

    assign state_o       = state_q;
    assign halted_o      = halt_now;
    assign timeout_err_o = timeout_q;

`ifdef STUMP_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (!halt_now) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
            if (step_done_o) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;
`endif

endmodule
